// File: rtl/cdb_arbiter_if.sv
// Producer/CDB bundle for cdb_arbiter: per-requester result handshake in, registered broadcast out.
interface cdb_arbiter_if #(
    parameter int N      = 4,
    parameter int TAG_W  = 8,
    parameter int DATA_W = 32
);
    logic [N-1:0]        req_valid;
    logic [N*TAG_W-1:0]  req_entry;
    logic [N*DATA_W-1:0] req_value;
    logic [N*DATA_W-1:0] req_addr;
    logic [N-1:0]        req_ready;
    logic                cdb_valid;
    logic [TAG_W-1:0]    cdb_entry;
    logic [DATA_W-1:0]   cdb_value;
    logic [DATA_W-1:0]   cdb_addr;
    logic [N-1:0]        pending;

    modport master (
        output req_valid, req_entry, req_value, req_addr,
        input  req_ready, cdb_valid, cdb_entry, cdb_value, cdb_addr, pending
    );

    modport slave (
        input  req_valid, req_entry, req_value, req_addr,
        output req_ready, cdb_valid, cdb_entry, cdb_value, cdb_addr, pending
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing one registered CDB among N result producers via one-deep slots.
// Latency: 2 edges from acceptance to broadcast, plus up to N-1 cycles under contention.
// Backpressure: req_ready drops while a slot is full and not being granted, and during flush.
module cdb_arbiter #(
    parameter int N      = 4,
    parameter int TAG_W  = 8,
    parameter int DATA_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    cdb_arbiter_if.slave bus
);
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] value;
        logic [DATA_W-1:0] addr;
    } slot_t;

    slot_t            slot_q [N];
    logic [N-1:0]     slot_v;
    logic [N-1:0]     gnt;
    logic [N-1:0]     ready;
    logic [N-1:0]     cap;
    logic             any_gnt;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] win;

    logic              cdb_valid_q;
    logic [TAG_W-1:0]  cdb_entry_q;
    logic [DATA_W-1:0] cdb_value_q;
    logic [DATA_W-1:0] cdb_addr_q;

    // First occupied slot at or after rr_ptr, wrapping modulo N.
    always_comb begin
        gnt     = '0;
        win     = '0;
        any_gnt = 1'b0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (int'(rr_ptr) + k) % N;
            if (!any_gnt && slot_v[idx]) begin
                any_gnt  = 1'b1;
                gnt[idx] = 1'b1;
                win      = PTR_W'(idx);
            end
        end
    end

    // A slot being granted this edge may be refilled on the same edge.
    assign ready = {N{~flush}} & (~slot_v | gnt);
    assign cap   = bus.req_valid & ready;

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (cap[i]) begin
                slot_q[i] <= '{tag:   bus.req_entry[i*TAG_W +: TAG_W],
                               value: bus.req_value[i*DATA_W +: DATA_W],
                               addr:  bus.req_addr[i*DATA_W +: DATA_W]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_v      <= '0;
            rr_ptr      <= '0;
            cdb_valid_q <= 1'b0;
            cdb_entry_q <= '0;
            cdb_value_q <= '0;
            cdb_addr_q  <= '0;
        end else if (flush) begin
            slot_v      <= '0;
            rr_ptr      <= '0;
            cdb_valid_q <= 1'b0;
            cdb_entry_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                // Tag 0 is accepted but never occupies the slot.
                if (cap[i]) begin
                    slot_v[i] <= |bus.req_entry[i*TAG_W +: TAG_W];
                end else if (gnt[i]) begin
                    slot_v[i] <= 1'b0;
                end
            end
            if (any_gnt) begin
                cdb_valid_q <= 1'b1;
                cdb_entry_q <= slot_q[win].tag;
                cdb_value_q <= slot_q[win].value;
                cdb_addr_q  <= slot_q[win].addr;
                rr_ptr      <= (win == PTR_W'(N - 1)) ? '0 : win + PTR_W'(1);
            end else begin
                cdb_valid_q <= 1'b0;
                cdb_entry_q <= '0;
            end
        end
    end

    assign bus.req_ready = ready;
    assign bus.pending   = slot_v;
    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_entry = cdb_entry_q;
    assign bus.cdb_value = cdb_value_q;
    assign bus.cdb_addr  = cdb_addr_q;
endmodule
